// File: rtl/clk_div_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// clk_div_pkg : shared constants and state encoding for clk_div_n
// Rev 1.0
//----------------------------------------------------------------------
package clk_div_pkg;

  localparam int C_CNT_W_DEFAULT = 8;
  localparam int C_DIV_MIN       = 2;

  // Divider run state {IDLE, RUN}
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/clk_div_n_half_cycle_retimer.sv
`default_nettype none
//----------------------------------------------------------------------
// half_cycle_retimer : single negedge flop isolating the dual-edge path
// Rev 1.0
//----------------------------------------------------------------------
module half_cycle_retimer
  import clk_div_pkg::*;
(
  input  logic clk_in,
  input  logic d,
  output logic q
);

  logic r_q;

  // No reset: the posedge domain clears d, so q follows within half a cycle.
  always_ff @(negedge clk_in) begin
    r_q <= d;
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_n.sv
`default_nettype none
//----------------------------------------------------------------------
// clk_div_n : runtime-programmable 50% duty divider, odd and even N
// Rev 1.0
//----------------------------------------------------------------------
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = C_CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 5
)
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_div,
  output logic             period_tick,
  output logic             load_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_DIV_MIN_W   = CNT_W'(C_DIV_MIN);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pos_q;
  logic             r_period_tick;
  logic             r_load_ack;
  logic             r_div_err;
  logic [CNT_W-1:0] r_div_active;
  logic             r_pend_valid;
  logic [CNT_W-1:0] r_pend_div;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_pos_nx;
  logic             w_tick_nx;
  logic             w_ack_nx;
  logic             w_err_nx;
  logic [CNT_W-1:0] w_div_nx;
  logic             w_pend_valid_nx;
  logic [CNT_W-1:0] w_pend_div_nx;

  logic [CNT_W:0]   w_half;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_boundary;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_neg_q;

  // Extra bit keeps (N+1) from wrapping at the top divisor.
  assign w_half     = ({1'b0, r_div_active} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  assign w_cnt_inc  = r_cnt + C_ONE;
  assign w_boundary = (r_state == ST_RUN) && (r_cnt == (r_div_active - C_ONE));
  assign w_load_ok  = div_load && (div_in >= C_DIV_MIN_W);
  assign w_load_bad = div_load && (div_in <  C_DIV_MIN_W);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_pos_nx        = r_pos_q;
    w_tick_nx       = 1'b0;
    w_ack_nx        = 1'b0;
    w_err_nx        = r_div_err | w_load_bad;
    w_div_nx        = r_div_active;
    w_pend_valid_nx = r_pend_valid;
    w_pend_div_nx   = r_pend_div;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        w_pos_nx = 1'b0;
        if (r_pend_valid) begin
          w_div_nx        = r_pend_div;
          w_pend_valid_nx = 1'b0;
          w_ack_nx        = 1'b1;
        end
        if (en) begin
          w_state_nx = ST_RUN;
          w_pos_nx   = 1'b1;
          w_tick_nx  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          w_cnt_nx = '0;
          // A load landing on the boundary edge takes effect immediately.
          if (w_load_ok) begin
            w_div_nx = div_in;
            w_ack_nx = 1'b1;
          end else if (r_pend_valid) begin
            w_div_nx = r_pend_div;
            w_ack_nx = 1'b1;
          end
          w_pend_valid_nx = 1'b0;
          if (en) begin
            w_pos_nx  = 1'b1;
            w_tick_nx = 1'b1;
          end else begin
            w_state_nx = ST_IDLE;
            w_pos_nx   = 1'b0;
          end
        end else begin
          w_cnt_nx = w_cnt_inc;
          w_pos_nx = ({1'b0, w_cnt_inc} < w_half);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_pos_nx   = 1'b0;
      end
    endcase

    if (w_load_ok && !w_boundary) begin
      w_pend_div_nx   = div_in;
      w_pend_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_pos_q       <= 1'b0;
      r_period_tick <= 1'b0;
      r_load_ack    <= 1'b0;
      r_div_err     <= 1'b0;
      r_div_active  <= C_DEFAULT_DIV;
      r_pend_valid  <= 1'b0;
      r_pend_div    <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_pos_q       <= w_pos_nx;
      r_period_tick <= w_tick_nx;
      r_load_ack    <= w_ack_nx;
      r_div_err     <= w_err_nx;
      r_div_active  <= w_div_nx;
      r_pend_valid  <= w_pend_valid_nx;
      r_pend_div    <= w_pend_div_nx;
    end
  end

  half_cycle_retimer u_retimer (
    .clk_in (clk_in),
    .d      (r_pos_q),
    .q      (w_neg_q)
  );

  // Parity only changes at a boundary, where pos_q=1 and neg_q=0, so the mux is quiet.
  assign clk_div     = r_div_active[0] ? (r_pos_q & w_neg_q) : r_pos_q;
  assign period_tick = r_period_tick;
  assign load_ack    = r_load_ack;
  assign div_err     = r_div_err;
  assign div_active  = r_div_active;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_n.sv
`default_nettype none
//----------------------------------------------------------------------
// tb_clk_div_n : self-checking bench for clk_div_n against a period model
// Rev 1.0
//----------------------------------------------------------------------
module tb_clk_div_n;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 5;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             clk_div;
  logic             period_tick;
  logic             load_ack;
  logic             div_err;
  logic [CNT_W-1:0] div_active;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: running flag, cycle index inside the current period, divisor.
  int m_run, m_ph, m_n, m_pend_v, m_pend, m_err, m_tick, m_ack;

  always #5 clk_in = ~clk_in;

  clk_div_n #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .div_in      (div_in),
    .div_load    (div_load),
    .clk_div     (clk_div),
    .period_tick (period_tick),
    .load_ack    (load_ack),
    .div_err     (div_err),
    .div_active  (div_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // 50% duty in half-cycle units: N half-cycles high, odd N starts half a cycle late.
  function automatic int exp_clk(input int half);
    int hidx, s;
    hidx = 2 * m_ph + half;
    s    = m_n % 2;
    return (m_run != 0 && hidx >= s && hidx < s + m_n) ? 1 : 0;
  endfunction

  task automatic model_edge();
    automatic bit ok   = 1'b0;
    automatic bit used = 1'b0;
    if (rst) begin
      m_run = 0; m_ph = 0; m_n = DEFAULT_DIV; m_pend_v = 0; m_pend = 0;
      m_err = 0; m_tick = 0; m_ack = 0;
    end else begin
      ok     = div_load && (int'(div_in) >= 2);
      m_tick = 0;
      m_ack  = 0;
      if (div_load && int'(div_in) < 2) m_err = 1;
      if (m_run == 0) begin
        if (m_pend_v != 0) begin m_n = m_pend; m_pend_v = 0; m_ack = 1; end
        if (en) begin m_run = 1; m_ph = 0; m_tick = 1; end
      end else if (m_ph == m_n - 1) begin
        if (ok) begin m_n = int'(div_in); used = 1'b1; m_ack = 1; end
        else if (m_pend_v != 0) begin m_n = m_pend; m_ack = 1; end
        m_pend_v = 0;
        if (en) begin m_ph = 0; m_tick = 1; end
        else m_run = 0;
      end else begin
        m_ph++;
      end
      if (ok && !used) begin m_pend = int'(div_in); m_pend_v = 1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("period_tick", 32'(period_tick), m_tick);
    chk("load_ack",    32'(load_ack),    m_ack);
    chk("div_err",     32'(div_err),     m_err);
    chk("div_active",  32'(div_active),  m_n);
    chk("clk_div_pos", 32'(clk_div),     exp_clk(0));
    @(negedge clk_in);
    #1;
    chk("clk_div_neg", 32'(clk_div),     exp_clk(1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int v);
    div_in   = 8'(v);
    div_load = 1'b1;
    cycle();
    div_load = 1'b0;
  endtask

  task automatic wait_ph(input int target);
    int k;
    k = 0;
    while ((m_run == 0 || m_ph != target) && k < 300) begin
      cycle();
      k++;
    end
    chk("wait_ph", 32'((m_run != 0 && m_ph == target) ? 1 : 0), 1);
  endtask

  initial begin
    m_run = 0; m_ph = 0; m_n = DEFAULT_DIV; m_pend_v = 0; m_pend = 0;
    m_err = 0; m_tick = 0; m_ack = 0;

    // Reset and default N=5 run
    run(3);
    rst = 1'b0;
    run(3);
    en = 1'b1;
    run(20);

    // Load 4 then 8 inside one period: only 8 is applied
    wait_ph(1);
    load(4);
    load(8);
    run(24);

    // Illegal divisors set the sticky error only
    load(1);
    run(2);
    load(0);
    run(10);
    load(5);
    run(12);

    // Graceful stop with N=7, then restart
    load(7);
    run(8);
    wait_ph(1);
    en = 1'b0;
    run(15);
    en = 1'b1;
    run(16);

    // N=3 then N=2
    load(3);
    run(12);
    load(2);
    run(10);

    // Reset during a high phase with a load pending
    load(9);
    run(10);
    wait_ph(1);
    load(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(12);

    // Load while idle, then start
    en = 1'b0;
    run(3);
    load(6);
    run(2);
    en = 1'b1;
    run(14);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_in   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(13, 255))
                                              : 8'($urandom_range(0, 12));
      rst      = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst      = 1'b0;
    div_load = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
